light_phase_sequencer: RTL and testbench
========================================

# light_phase_sequencer

Runtime core of the traffic-light controller. It divides the 25 MHz system clock down to a 1 Hz tick and steps a six-phase car/pedestrian cycle. It counts down the seconds remaining in each phase and lets the operator edit each phase's duration with the debounced button pulses while in set mode. It sits between the four button debouncers and the display controller, and drives the `phase`/`s_num` pair that the display controller decodes into lamp, 7-segment, LED and VGA output.

## Interface
Parameters:
- `CLK_HZ`, default 25_000_000: clock cycles per second tick. Benches override it with a small value.
- `D0`..`D5`, defaults 9, 3, 1, 9, 4, 1: reset durations in seconds for phases 0..5. Each is 4-bit, range 1..15.

Ports:
- `clk`, input, 1: single clock (25 MHz in system).
- `rst`, input, 1: asynchronous, active-high reset.
- `set`, input, 1: level. 1 = edit mode, 0 = run mode. Not synchronised inside the block; the caller drives it synchronous to `clk`.
- `up`, input, 1: one-cycle pulse. In edit mode, increments the selected phase's duration.
- `down`, input, 1: one-cycle pulse. In edit mode, decrements the selected phase's duration.
- `left`, input, 1: one-cycle pulse. In edit mode, selects the previous phase.
- `right`, input, 1: one-cycle pulse. In edit mode, selects the next phase.
- `phase`, output, 3: in run mode, the current phase; in edit mode, the phase selected for editing. Range 0..5.
- `s_num`, output, 4: in run mode, the seconds remaining in the phase; in edit mode, the selected phase's duration.
- `sec_tick`, output, 1: one-cycle pulse once per second, run mode only.

## Operation
Phase meaning, consumed by the display controller:
- 0: car green, man red.
- 1: car yellow, man red.
- 2: all red.
- 3: car red, man walk.
- 4: car red, man flashing.
- 5: all red.

State:
- `dur[0..5]`: 4-bit duration registers.
- `sel`: 3-bit edit selection.
- `run_ph`: 3-bit running phase.
- `cnt`: 4-bit seconds remaining.
- `pre`: prescaler, width clog2(CLK_HZ).
- `set_d`: 1-bit registered copy of `set`.

Mode FSM has two states, RUN and EDIT, selected directly by `set`. Transitions are detected through `set_d`.

RUN behaviour:
- `pre` counts 0..CLK_HZ-1 and wraps. `sec_tick` is 1 in the cycle after `pre` equals CLK_HZ-1.
- On each tick, if `cnt` > 1: `cnt` decrements.
- On each tick, if `cnt` == 1: `run_ph` advances (5 wraps to 0) and `cnt` loads `dur[next]`. Each phase therefore lasts exactly `dur` seconds.
- `up`, `down`, `left` and `right` are ignored.
- Outputs: `phase` = `run_ph`, `s_num` = `cnt`.

Entering EDIT (rising edge of `set`):
- `sel` is set to 0.
- `pre` is cleared and held at 0.
- `sec_tick` is held at 0.
- `run_ph` and `cnt` are frozen.

EDIT behaviour:
- `right`: `sel` = `sel`+1, with 5 wrapping to 0.
- `left`: `sel` = `sel`-1, with 0 wrapping to 5.
- `up`: `dur[sel]` increments, saturating at 15.
- `down`: `dur[sel]` decrements, saturating at 1.
- Outputs: `phase` = `sel`, `s_num` = `dur[sel]`.

Simultaneous events:
- `up` and `down` in the same cycle: no duration change.
- `left` and `right` in the same cycle: no selection change.
- A selection pulse together with an adjust pulse in the same cycle: the adjust applies to the old `sel`, and `sel` moves in the same edge.

Leaving EDIT (falling edge of `set`):
- The cycle restarts: `run_ph` = 0, `cnt` = `dur[0]` (including any new value), `pre` = 0.
- The first tick follows CLK_HZ cycles later.

Reset, asynchronous at any time including mid-edit or mid-phase:
- `dur[i]` = `Di`.
- `sel` = 0, `run_ph` = 0, `cnt` = `D0`, `pre` = 0, `set_d` = 0.
- Outputs: `phase` = 0, `s_num` = `D0` (9 by default), `sec_tick` = 0.
- Durations edited before reset are lost.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Button pulse at edge n: `phase`/`s_num` show the updated value after edge n+1.
- `set` rise at edge n: `phase` = 0 and `s_num` = `dur[0]` after edge n+1.
- `set` fall at edge n: run restart is visible after edge n+1.
- `sec_tick` period is exactly CLK_HZ cycles and its width is exactly 1 cycle.
- Phase change and `s_num` reload occur in the same cycle as `sec_tick`.
- A full cycle takes sum(`dur`) seconds, 27 s with the defaults.
- After `rst` deasserts, the first tick occurs CLK_HZ cycles later.

## Test plan
All scenarios use CLK_HZ = 4.
- **Reset and run:** release reset and run 30 ticks. `s_num` counts 9..1 in phase 0, then phase 1 shows 3,2,1, then phase 2 shows 1. Phase wraps 5→0 after tick 27. `sec_tick` fires every 4 cycles.
- **Edit saturation:** set=1, then 8×`up` on phase 0. `s_num` reads 15 and stays at 15. Then 20×`down`: `s_num` reads 1. Release set: run restarts in phase 0 with `s_num` = 1, and phase 1 begins after 1 tick.
- **Selection wrap:** in edit, `left` → `phase` = 5. `right` ×2 → `phase` = 1. `up` on phase 1 → `s_num` = 4. Leaving and running shows phase 1 lasting 4 ticks.
- **Simultaneous pulses:** `up` and `down` in the same cycle leaves the duration unchanged. `left` and `right` together leave `sel` unchanged. `right` with `up` increments the old `sel` and `sel` advances.
- **Ignored in run:** `up`/`down`/`left`/`right` pulses while set=0 change nothing; durations and phase sequence match the defaults.
- **Async reset mid-edit:** after editing `dur[3]` to 12, assert `rst` mid-cycle (not on a clock edge). Outputs go to 0/9 immediately. After release, phase 3 lasts 9 ticks and `sec_tick` is 0 until 4 cycles after release.

Source files
------------

// File: rtl/light_phase_sequencer.sv
// rtl/light_phase_sequencer.sv - six-phase traffic-light sequencer with 1 Hz prescaler and duration editing
//
// Divides clk by CLK_HZ into a one-cycle sec_tick and steps phases 0..5,
// counting down the seconds left in each. With set=1 the operator selects a
// phase (left/right) and edits its duration (up/down, saturating 1..15).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   set                   1 = edit mode, 0 = run mode (synchronous to clk)
//   up, down              one-cycle pulses: adjust selected duration (edit only)
//   left, right           one-cycle pulses: move edit selection (edit only)
//   phase[2:0]            running phase (run) or selected phase (edit)
//   s_num[3:0]            seconds remaining (run) or selected duration (edit)
//   sec_tick              one-cycle pulse per second, run mode only
module light_phase_sequencer #(
  parameter int CLK_HZ = 25_000_000,
  parameter int D0 = 9,
  parameter int D1 = 3,
  parameter int D2 = 1,
  parameter int D3 = 9,
  parameter int D4 = 4,
  parameter int D5 = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [2:0] phase,
  output logic [3:0] s_num,
  output logic       sec_tick
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

  // Mode FSM; the state register is the registered copy of set.
  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_EDIT = 1'b1;

  logic [5:0][3:0]  dur_q, dur_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       run_ph_q, run_ph_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             set_d_q, set_d_d;
  logic [2:0]       phase_q, phase_d;
  logic [3:0]       s_num_q, s_num_d;
  logic             sec_tick_q, sec_tick_d;

  logic             entering;
  logic             leaving;
  logic [2:0]       run_nxt;

  always_comb begin
    dur_d      = dur_q;
    sel_d      = sel_q;
    run_ph_d   = run_ph_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    sec_tick_d = 1'b0;
    set_d_d    = set ? ST_EDIT : ST_RUN;
    entering   = set && (set_d_q == ST_RUN);
    leaving    = !set && (set_d_q == ST_EDIT);
    run_nxt    = (run_ph_q == 3'd5) ? 3'd0 : run_ph_q + 3'd1;

    if (set) begin
      // Prescaler is parked at zero for the whole edit session.
      pre_d = '0;
      if (entering) begin
        sel_d = 3'd0;
      end else begin
        // Adjust targets the old selection even if sel moves on this edge.
        if (up && !down && dur_q[sel_q] != 4'd15) begin
          dur_d[sel_q] = dur_q[sel_q] + 4'd1;
        end else if (down && !up && dur_q[sel_q] != 4'd1) begin
          dur_d[sel_q] = dur_q[sel_q] - 4'd1;
        end
        if (right && !left) begin
          sel_d = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
        end else if (left && !right) begin
          sel_d = (sel_q == 3'd0) ? 3'd5 : sel_q - 3'd1;
        end
      end
    end else if (leaving) begin
      run_ph_d = 3'd0;
      cnt_d    = dur_q[0];
      pre_d    = '0;
    end else if (pre_q == PRE_MAX) begin
      pre_d      = '0;
      sec_tick_d = 1'b1;
      if (cnt_q > 4'd1) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        run_ph_d = run_nxt;
        cnt_d    = dur_q[run_nxt];
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    // Outputs are registered from next state so they line up with sec_tick.
    phase_d = set ? sel_d : run_ph_d;
    s_num_d = set ? dur_d[sel_d] : cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_q      <= {4'(D5), 4'(D4), 4'(D3), 4'(D2), 4'(D1), 4'(D0)};
      sel_q      <= 3'd0;
      run_ph_q   <= 3'd0;
      cnt_q      <= 4'(D0);
      pre_q      <= '0;
      set_d_q    <= ST_RUN;
      phase_q    <= 3'd0;
      s_num_q    <= 4'(D0);
      sec_tick_q <= 1'b0;
    end else begin
      dur_q      <= dur_d;
      sel_q      <= sel_d;
      run_ph_q   <= run_ph_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      set_d_q    <= set_d_d;
      phase_q    <= phase_d;
      s_num_q    <= s_num_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign phase    = phase_q;
  assign s_num    = s_num_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// tb/tb_light_phase_sequencer.sv - scoreboard bench for light_phase_sequencer
module tb_light_phase_sequencer;

  localparam int CLK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       set;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [2:0] phase;
  logic [3:0] s_num;
  logic       sec_tick;

  light_phase_sequencer #(.CLK_HZ(CLK)) dut (
    .clk(clk), .rst(rst), .set(set), .up(up), .down(down),
    .left(left), .right(right), .phase(phase), .s_num(s_num),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    logic [3:0] sn;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   mdur[6];
  int   msel;

  function automatic void model_reset();
    mdur[0] = 9; mdur[1] = 3; mdur[2] = 1;
    mdur[3] = 9; mdur[4] = 4; mdur[5] = 1;
    msel = 0;
  endfunction

  task automatic push_exp(input int ph, input int sn);
    exp_t e;
    e.ph = 3'(ph);
    e.sn = 4'(sn);
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, got phase/s_num %0d/%0d", tag, phase, s_num);
    end else begin
      e = exp_q.pop_front();
      assert (phase === e.ph && s_num === e.sn) passed++;
      else $error("FAIL %s: phase/s_num %0d/%0d expected %0d/%0d",
                  tag, phase, s_num, e.ph, e.sn);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Expected (phase, s_num) after each of the next n ticks of a fresh cycle.
  task automatic push_run(input int n);
    int ph;
    int c;
    ph = 0;
    c  = mdur[0];
    for (int i = 0; i < n; i++) begin
      if (c > 1) begin
        c--;
      end else begin
        ph = (ph == 5) ? 0 : ph + 1;
        c  = mdur[ph];
      end
      push_exp(ph, c);
    end
  endtask

  // Waits for n ticks, checking spacing and the scoreboard at each one.
  task automatic check_ticks(input int n, input int first, input bit noise);
    int cyc;
    bit got;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 3 * CLK) begin
        @(posedge clk);
        #1;
        cyc++;
        if (noise) begin
          up    = 1'($urandom_range(0, 1));
          down  = 1'($urandom_range(0, 1));
          left  = 1'($urandom_range(0, 1));
          right = 1'($urandom_range(0, 1));
        end
        if (sec_tick === 1'b1) got = 1'b1;
      end
      check_val($sformatf("tick%0d_spacing", i), cyc, (i == 0) ? first : CLK);
      if (!got) begin
        void'(exp_q.pop_front());
      end else begin
        check_out($sformatf("tick%0d_out", i));
      end
    end
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task automatic set_enter();
    @(negedge clk);
    set = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    msel = 0;
    push_exp(0, mdur[0]);
    check_out("enter_edit");
  endtask

  task automatic set_exit();
    @(negedge clk);
    set = 1'b0;
    @(posedge clk);
    #1;
    push_exp(0, mdur[0]);
    check_out("exit_edit");
  endtask

  task automatic pulse(input string tag, input logic u, input logic d,
                       input logic l, input logic r);
    @(negedge clk);
    up = u; down = d; left = l; right = r;
    @(negedge clk);
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    @(posedge clk);
    #1;
    if (u && !d) mdur[msel] = (mdur[msel] < 15) ? mdur[msel] + 1 : 15;
    else if (d && !u) mdur[msel] = (mdur[msel] > 1) ? mdur[msel] - 1 : 1;
    if (r && !l) msel = (msel == 5) ? 0 : msel + 1;
    else if (l && !r) msel = (msel == 0) ? 5 : msel - 1;
    push_exp(msel, mdur[msel]);
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1; set = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    model_reset();

    // Reset state and a full run past the 5 -> 0 wrap.
    repeat (3) @(posedge clk);
    #1;
    push_exp(0, 9);
    check_out("reset_state");
    check_val("reset_tick", int'(sec_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    push_run(30);
    check_ticks(30, CLK, 1'b0);

    // Edit saturation on phase 0.
    set_enter();
    for (int i = 0; i < 8; i++) pulse($sformatf("up_sat%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) pulse($sformatf("down_sat%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("edit_no_tick", int'(sec_tick), 0);
    set_exit();
    push_run(2);
    check_ticks(2, CLK, 1'b0);

    // Selection wrap and edit of phase 1.
    set_enter();
    pulse("left_wrap", 1'b0, 1'b0, 1'b1, 1'b0);
    pulse("right_wrap", 1'b0, 1'b0, 1'b0, 1'b1);
    pulse("right_1", 1'b0, 1'b0, 1'b0, 1'b1);
    pulse("up_ph1", 1'b1, 1'b0, 1'b0, 1'b0);
    set_exit();
    push_run(6);
    check_ticks(6, CLK, 1'b0);

    // Simultaneous pulses.
    set_enter();
    pulse("up_down", 1'b1, 1'b1, 1'b0, 1'b0);
    pulse("left_right", 1'b0, 1'b0, 1'b1, 1'b1);
    pulse("right_up", 1'b1, 1'b0, 1'b0, 1'b1);
    pulse("left_up", 1'b1, 1'b0, 1'b1, 1'b0);
    set_exit();

    // Asynchronous reset in the middle of an edit session.
    set_enter();
    for (int i = 0; i < 3; i++) pulse($sformatf("sel3_%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) pulse($sformatf("dur3_%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    push_exp(0, 9);
    check_out("async_rst_out");
    check_val("async_rst_tick", int'(sec_tick), 0);
    @(negedge clk);
    set = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Buttons toggle randomly throughout this run and must be ignored.
    push_run(22);
    check_ticks(22, CLK, 1'b1);

    // Durations are still the defaults after the noisy run.
    set_enter();
    for (int i = 0; i < 6; i++) pulse($sformatf("dflt_sel%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    set_exit();

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
